// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : byte/half/word load-store sequencer between a pipeline
//                   request/response handshake and a single-port sync memory.
// Revision        : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        MemRead,
  output logic        MemWrite
);

  localparam logic [2:0] C_IDLE    = 3'd0;
  localparam logic [2:0] C_READ    = 3'd1;
  localparam logic [2:0] C_CAPTURE = 3'd2;
  localparam logic [2:0] C_WRITE   = 3'd3;
  localparam logic [2:0] C_RESP    = 3'd4;

  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;
  localparam logic [1:0] C_SZ_ILL  = 2'b11;

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        w_req_err;
  logic [4:0]  w_lane_shift;
  logic [31:0] w_lane_mask;
  logic [15:0] w_lane_data;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  // Request legality is judged on the live inputs so the error path can
  // skip straight to RESP on the accept edge.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      C_SZ_HALF: w_req_err = req_addr[0];
      C_SZ_WORD: w_req_err = |req_addr[1:0];
      C_SZ_ILL:  w_req_err = 1'b1;
      default:   w_req_err = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
      w_req_err = 1'b1;
    end
  end

  always_comb begin
    w_lane_shift = (size_q == C_SZ_HALF) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    w_lane_mask  = (size_q == C_SZ_HALF) ? (32'h0000_FFFF << w_lane_shift)
                                         : (32'h0000_00FF << w_lane_shift);
    w_lane_data  = 16'(mem_rdata >> w_lane_shift);
    w_merged     = (mem_rdata & ~w_lane_mask) | ((wdata_q << w_lane_shift) & w_lane_mask);
    case (size_q)
      C_SZ_BYTE: w_load_ext = {{24{w_lane_data[7] & ~unsigned_q}}, w_lane_data[7:0]};
      C_SZ_HALF: w_load_ext = {{16{w_lane_data[15] & ~unsigned_q}}, w_lane_data};
      default:   w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      C_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          size_d       = req_size;
          unsigned_d   = req_unsigned;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_rdata_d = 32'd0;
          resp_err_d   = w_req_err;
          if (w_req_err) begin
            state_d = C_RESP;
          end else if (req_we && (req_size == C_SZ_WORD)) begin
            mem_wdata_d = req_wdata;
            state_d     = C_WRITE;
          end else begin
            state_d = C_READ;
          end
        end
      end
      C_READ:    state_d = C_CAPTURE;
      C_CAPTURE: begin
        // Sub-word stores merge here; loads extend and finish.
        if (we_q) begin
          mem_wdata_d = w_merged;
          state_d     = C_WRITE;
        end else begin
          resp_rdata_d = w_load_ext;
          state_d      = C_RESP;
        end
      end
      C_WRITE:   state_d = C_RESP;
      C_RESP: begin
        if (resp_ready) begin
          state_d = C_IDLE;
        end
      end
      default:   state_d = C_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == C_IDLE);
    MemRead    = (state_q == C_READ);
    MemWrite   = (state_q == C_WRITE);
    resp_valid = (state_q == C_RESP);
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
    mem_addr   = {2'b00, addr_q[31:2]};
    mem_wdata  = mem_wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : self-checking bench with directed and random traffic
//                      against a word-array reference memory.
// Revision           : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  localparam int MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        MemRead;
  logic        MemWrite;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite)
  );

  // Memory with registered read; read data is garbage outside the valid cycle.
  logic [31:0] mem [MEM_WORDS];
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (MemRead) begin
      mem_rdata <= mem[mem_addr[4:0]];
      rd_cnt    <= rd_cnt + 1;
    end else begin
      mem_rdata <= $urandom;
    end
    if (MemWrite) begin
      mem[mem_addr[4:0]] <= mem_wdata;
      wr_cnt             <= wr_cnt + 1;
    end
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
  end

  logic [31:0] ref_mem [MEM_WORDS];

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= MEM_WORDS);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                            input bit uns, input logic [31:0] addr);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * (addr % 4))) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (word >> (16 * ((addr / 2) % 2))) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                             input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] sh, unit, old_lane, new_lane;
    if (size == 2'd2) return wdata;
    unit     = (size == 2'd0) ? 32'd256 : 32'd65536;
    sh       = (size == 2'd0) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
    old_lane = (word >> sh) % unit;
    new_lane = wdata % unit;
    return word - (old_lane << sh) + (new_lane << sh);
  endfunction

  // Starts at a negedge with the unit idle; returns at the negedge where
  // resp_valid is first seen (lat = cycles after the accept edge).
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      resp_ready = 1'($urandom);
      req_valid  = 1'($urandom);
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic take_resp(output bit idle_after);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    idle_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({MemRead, MemWrite, resp_valid, resp_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {MemRead, MemWrite, resp_valid, resp_err}); end
    n_cmp++; if (resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00000000", resp_rdata); end
    n_cmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_fill();
    int lat, rd0, wr0; bit idle; logic [31:0] v;
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = (i == 3) ? 32'h8899_AABB : $urandom;
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue(1'b1, 2'd2, 1'b0, 32'(4 * i), v, lat);
      n_cmp++; if (lat !== 2 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
        n_fail++; $display("FAIL sw_resp[%0d]: got lat %0d err %b rdata %h want 2/0/0", i, lat, resp_err, resp_rdata); end
      take_resp(idle);
      n_cmp++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 1 || !idle) begin
        n_fail++; $display("FAIL sw_strobes[%0d]: got rd %0d wr %0d idle %b want 0/1/1", i, rd_cnt - rd0, wr_cnt - wr0, idle); end
      ref_mem[i] = v;
    end
  endtask

  task automatic test_load_word();
    int lat, rd0, wr0; bit idle;
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_cmp++; if (mem_addr !== 32'd3) begin n_fail++; $display("FAIL lw_mem_addr: got %h want 3", mem_addr); end
    n_cmp++; if (resp_rdata !== 32'h8899_AABB || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL lw_data: got %h err %b want 8899aabb err 0", resp_rdata, resp_err); end
    take_resp(idle);
    n_cmp++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0 || !idle) begin
      n_fail++; $display("FAIL lw_strobes: got rd %0d wr %0d idle %b want 1/0/1", rd_cnt - rd0, wr_cnt - wr0, idle); end
  endtask

  task automatic test_byte_loads();
    int lat; bit idle;
    logic [1:0]  sz  [3] = '{2'd0, 2'd0, 2'd1};
    bit          un  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [3] = '{32'h0F, 32'h0F, 32'h0C};
    logic [31:0] exp [3] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_AABB};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sz[i], un[i], ad[i], 32'd0, lat);
      n_cmp++; if (resp_rdata !== exp[i] || resp_err !== 1'b0 || lat !== 3) begin
        n_fail++; $display("FAIL subword_load[%0d]: got %h err %b lat %0d want %h/0/3", i, resp_rdata, resp_err, lat, exp[i]); end
      take_resp(idle);
    end
  endtask

  task automatic test_half_rmw();
    int lat, rd0, wr0; bit idle;
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 2'd1, 1'b0, 32'h0E, 32'hCAFE_1234, lat);
    n_cmp++; if (lat !== 4 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL sh_resp: got lat %0d err %b rdata %h want 4/0/0", lat, resp_err, resp_rdata); end
    take_resp(idle);
    n_cmp++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin
      n_fail++; $display("FAIL sh_strobes: got rd %0d wr %0d want 1/1", rd_cnt - rd0, wr_cnt - wr0); end
    n_cmp++; if (mem[3] !== 32'h1234_AABB) begin
      n_fail++; $display("FAIL sh_mem: got %h want 1234aabb", mem[3]); end
    ref_mem[3] = 32'h1234_AABB;
    issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, lat);
    n_cmp++; if (resp_rdata !== 32'h1234_AABB) begin
      n_fail++; $display("FAIL sh_readback: got %h want 1234aabb", resp_rdata); end
    take_resp(idle);
  endtask

  task automatic test_errors();
    int lat, rd0, wr0; bit idle;
    bit          we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h0D, 32'h01, 32'h04, 32'h80};
    for (int i = 0; i < 4; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue(we[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA, lat);
      n_cmp++; if (resp_err !== 1'b1 || resp_rdata !== 32'd0 || lat !== 1) begin
        n_fail++; $display("FAIL err_resp[%0d]: got err %b rdata %h lat %0d want 1/0/1", i, resp_err, resp_rdata, lat); end
      take_resp(idle);
      n_cmp++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0 || !idle) begin
        n_fail++; $display("FAIL err_strobes[%0d]: got rd %0d wr %0d idle %b want 0/0/1", i, rd_cnt - rd0, wr_cnt - wr0, idle); end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit idle; logic [31:0] r0; logic e0;
    issue(1'b0, 2'd0, 1'b0, 32'h15, 32'd0, lat);
    r0 = resp_rdata; e0 = resp_err;
    n_cmp++; if (r0 !== ref_load(ref_mem[5], 2'd0, 1'b0, 32'h15)) begin
      n_fail++; $display("FAIL bp_data: got %h want %h", r0, ref_load(ref_mem[5], 2'd0, 1'b0, 32'h15)); end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== r0 || resp_err !== e0 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v %b d %h e %b rdy %b want 1/%h/%b/0", c, resp_valid, resp_rdata, resp_err, req_ready, r0, e0); end
    end
    take_resp(idle);
    n_cmp++; if (!idle || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got ready %b valid %b want 1/0", idle, resp_valid); end
  endtask

  task automatic test_reset_mid_store();
    int wr0; bit idle; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr0 = wr_cnt;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0 || MemWrite !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_outputs[%0d]: got valid %b write %b want 0/0", c, resp_valid, MemWrite); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    n_cmp++; if (wr_cnt !== wr0 || mem[5] !== ref_mem[5]) begin
      n_fail++; $display("FAIL rst_mid_mem: got writes %0d word %h want 0/%h", wr_cnt - wr0, mem[5], ref_mem[5]); end
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, lat);
    n_cmp++; if (resp_rdata !== ref_mem[5]) begin
      n_fail++; $display("FAIL rst_mid_readback: got %h want %h", resp_rdata, ref_mem[5]); end
    take_resp(idle);
  endtask

  task automatic test_back_to_back();
    int n_rdy = 0, n_rsp = 0, n_both = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 32'h0; resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (req_ready === 1'b1) n_rdy++;
      if (resp_valid === 1'b1) n_rsp++;
      if (req_ready === 1'b1 && resp_valid === 1'b1) n_both++;
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    n_cmp++; if (n_rdy !== 5 || n_rsp !== 5 || n_both !== 0) begin
      n_fail++; $display("FAIL b2b_rate: got ready %0d resp %0d overlap %0d want 5/5/0", n_rdy, n_rsp, n_both); end
  endtask

  task automatic test_random();
    int lat, rd0, wr0, exp_lat, exp_rd, exp_wr; bit idle, we, un, err;
    logic [1:0] sz; logic [31:0] ad, wd, exp_d;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom); un = 1'($urandom); sz = 2'($urandom); wd = $urandom;
      case ($urandom % 8)
        0:       ad = $urandom;
        1:       ad = 32'($urandom_range(4 * MEM_WORDS, 4 * MEM_WORDS + 7));
        default: ad = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      endcase
      err     = ref_err(sz, ad);
      exp_lat = err ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 4));
      exp_rd  = (!err && !(we && sz == 2'd2)) ? 1 : 0;
      exp_wr  = (!err && we) ? 1 : 0;
      exp_d   = (err || we) ? 32'd0 : ref_load(ref_mem[ad / 4], sz, un, ad);
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue(we, sz, un, ad, wd, lat);
      n_cmp++; if (resp_err !== err || resp_rdata !== exp_d || lat !== exp_lat) begin
        n_fail++; $display("FAIL rand_resp[%0d]: got err %b d %h lat %0d want %b/%h/%0d", i, resp_err, resp_rdata, lat, err, exp_d, exp_lat); end
      n_cmp++; if (mem_addr !== {2'b00, ad[31:2]}) begin
        n_fail++; $display("FAIL rand_addr[%0d]: got %h want %h", i, mem_addr, {2'b00, ad[31:2]}); end
      take_resp(idle);
      n_cmp++; if (rd_cnt - rd0 !== exp_rd || wr_cnt - wr0 !== exp_wr || !idle) begin
        n_fail++; $display("FAIL rand_strobes[%0d]: got rd %0d wr %0d idle %b want %0d/%0d/1", i, rd_cnt - rd0, wr_cnt - wr0, idle, exp_rd, exp_wr); end
      if (!err && we) ref_mem[ad / 4] = ref_store(ref_mem[ad / 4], sz, ad, wd);
    end
  endtask

  task automatic test_final_memory();
    for (int i = 0; i < MEM_WORDS; i++) begin
      n_cmp++; if (mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL mem_word[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
    end
    n_cmp++; if (both_cnt !== 0) begin
      n_fail++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_word();
    test_byte_loads();
    test_half_rmw();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    test_final_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
